mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline: sits between the EX→MEM pipeline register and the MEM→WB register. It holds the data memory, performs word loads and stores addressed by the ALU result, and models a multi-cycle memory with an access counter. A `freeze` output stalls all upstream stages and the EX→MEM register until the access completes. `memReadOut` feeds the MEM→WB register's memory-read input directly.

## Interface
- `ADDR_W`, 8: word-address width; memory holds 2^ADDR_W 32-bit words.
- `LAT`, 4: access latency in cycles, from request seen to access complete; legal range 1..15.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on `clk` rising edge.
- `MEM_R_EN` in 1: load request, held stable by upstream while `freeze`=1.
- `MEM_W_EN` in 1: store request, held stable by upstream while `freeze`=1.
- `ALUResIn` in 32: byte address; word index = `ALUResIn[ADDR_W+1:2]`.
- `valRmIn` in 32: store data.
- `memReadOut` out 32: load data, valid in the completion cycle.
- `freeze` out 1: stall to upstream and the EX→MEM register.
- `misalign` out 1: present only with `MEM_MISALIGN_CHK_EN`.

## Operation
- FSM states: IDLE, BUSY. Counter `cnt`, 4 bits.
- `req` = `MEM_R_EN | MEM_W_EN`. `done` = `req & (cnt == LAT-1)`.
- IDLE, `req`=0: stay IDLE, `cnt`=0.
- IDLE, `req`=1, `LAT`=1: `done` is high immediately; access completes this cycle; stay IDLE.
- IDLE, `req`=1, `LAT`>1: go to BUSY, `cnt` ← 1.
- BUSY, not `done`: `cnt` ← `cnt`+1.
- BUSY, `done`: go to IDLE, `cnt` ← 0.
- BUSY, `req` dropped (upstream protocol violation): return to IDLE, `cnt` ← 0, no write.
- `freeze` = `req & ~done`. This is combinational, so the stall is visible in the same cycle the request arrives.
- Store: memory word written at the clock edge ending the `done` cycle; exactly one write per request.
- Load: `memReadOut` = memory[index], combinational from the array. It is required valid only when `done`=1; the MEM→WB register captures it then.
- `MEM_R_EN` and `MEM_W_EN` both high: treated as a store. `memReadOut` shows the pre-write word.
- Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo memory size. Bits [1:0] are ignored unless the checker is compiled in.

## Timing
- Reset: state IDLE, `cnt`=0, every memory word 0, `freeze`=0 in the reset cycle regardless of `req`, `misalign`=0.
- Reset asserted mid-access: the access is aborted, no write commits, and the FSM is IDLE the next cycle.
- Load/store latency: `LAT` cycles. `freeze` is high for the first `LAT-1` of them.
- Back-to-back requests: a new request is accepted in the cycle after `done` with no idle gap. Store then load to the same address returns the new data.
- No request is lost or duplicated while `freeze`=1.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined:
  - `misalign` = `req & (ALUResIn[1:0] != 0)`, combinational.
  - A misaligned request completes in 1 cycle: `freeze`=0 and the FSM stays IDLE.
  - A misaligned store is suppressed; a misaligned load returns 0.
- Not defined: `misalign` port absent; low address bits ignored and every access is treated as aligned.

## Test plan
- Reset, then idle with `LAT`=4 → `freeze`=0, `memReadOut`=0 for addresses 0, 4, 1020.
- Store 0xDEADBEEF to 0x10, `LAT`=4 → `freeze` high 3 cycles; a later load of 0x10 returns 0xDEADBEEF after 3 freeze cycles.
- Store to 0x10, then load 0x10 in the very next cycle → second access returns the new value, with no idle cycle between the accesses.
- `LAT`=1: store 0x5 to 0x20, then load 0x20 → `freeze` never asserts; load returns 0x5.
- Assert `rst` in cycle 2 of a store of 0x1234 to 0x40 → FSM is IDLE next cycle; a load of 0x40 returns 0.
- With `MEM_MISALIGN_CHK_EN`: store to 0x22 → `misalign`=1, `freeze`=0, and 0x20 is unchanged. Without the macro: the same store writes word 0x20.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store into a local data memory with a
// fixed multi-cycle latency and a stall output. Optional checker: MEM_MISALIGN_CHK_EN.
module mem_stage #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] valRmIn,
  output logic [31:0] memReadOut,
  output logic        freeze,
`ifdef MEM_MISALIGN_CHK_EN
  output logic        misalign,
`endif
  output logic        fsm_state,
  output logic [3:0]  fsm_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Handshake: upstream holds MEM_R_EN/MEM_W_EN and operands stable while freeze=1;
  // the access is taken (and a load result consumed) in the cycle where req=1, freeze=0.

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        req, done, mis, wr;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [DEPTH];

  wire unused_addr_bits = ^{ALUResIn[31:ADDR_W+2], ALUResIn[1:0]};

  assign req = MEM_R_EN | MEM_W_EN;
  assign idx = ALUResIn[ADDR_W+1:2];

`ifdef MEM_MISALIGN_CHK_EN
  assign mis = req & (ALUResIn[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // A misaligned request finishes immediately without touching the memory.
  assign done = req & (mis | (cnt == 4'(LAT - 1)));
  assign wr   = MEM_W_EN & done & ~mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req && !done) begin
          state_n = BUSY;
          cnt_n   = 4'd1;
        end else begin
          cnt_n   = 4'd0;
        end
      end
      BUSY: begin
        // Dropping req mid-access abandons it; no write happens since done needs req.
        if (!req || done) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n   = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_comb begin
    freeze     = req & ~done & ~rst;
    memReadOut = mis ? 32'd0 : mem[idx];
    fsm_state  = state;
    fsm_cnt    = cnt;
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = mis;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (wr) begin
      mem[idx] <= valRmIn;
    end
  end

endmodule
